dark_mem_arbiter: RTL and testbench
===================================

// Module: dark_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the darkriscv core's
//  instruction-fetch port (IADDR/IDATA) and data port (DADDR/DATAO/DATAI/BE/WR/RD).
//  It sequences up to two memory accesses per core step, holds the core with HLT
//  while they run, and returns registered IDATA/DATAI. Sits between core and RAM.
// PARAMETERS
//  MEM_LAT   1   memory read latency in cycles, legal 1..4 (MRD in cycle t -> MRDATA valid in cycle t+MEM_LAT)
//  DATA_PRIO 1   1: data access before fetch; 0: fetch before data access
// PORTS
//  CLK     in   1   clock, all logic on posedge
//  RES     in   1   synchronous reset, ACTIVE-LOW (sampled on CLK)
//  IADDR   in   32  core fetch address
//  IDATA   out  32  fetched instruction, registered
//  DADDR   in   32  core data address
//  DATAO   in   32  core store data
//  DATAI   out  32  load data, registered
//  BE      in   4   core byte enables
//  WR      in   1   core store request
//  RD      in   1   core load request
//  HLT     out  1   stall to core; 0 only in the RELEASE cycle
//  MADDR   out  32  memory address
//  MWDATA  out  32  memory write data
//  MBE     out  4   memory byte enables
//  MWR     out  1   memory write strobe, 1 cycle per store
//  MRD     out  1   memory read strobe, 1 cycle per read
//  MRDATA  in   32  memory read data
//  ERR     out  1   sticky: RD and WR both high when sampled in ISSUE
//  STALLS  out  32  count of HLT=1 cycles since reset, saturates at 2^32-1
// BEHAVIOUR
//  - Reset (RES=0 at an edge): state=ISSUE, step pending-list rebuilt, HLT=1, MRD=0, MWR=0,
//    MADDR/MWDATA=0, MBE=0, IDATA=0, DATAI=0, ERR=0, STALLS=0. In-flight read data discarded.
//  - FSM states: ISSUE, WAIT, RELEASE.
//    ISSUE: on entry from RELEASE/reset, sample RD/WR/IADDR/DADDR/DATAO/BE; queue
//      {data, fetch} (ordered by DATA_PRIO; data only if RD|WR). Issue the queue head:
//      read -> MRD=1 for this cycle, MADDR=address; go WAIT.
//      write -> MWR=1, MADDR=DADDR, MWDATA=DATAO, MBE=BE this cycle; pop; stay ISSUE if
//      queue non-empty, else RELEASE.
//    WAIT: count MEM_LAT cycles; on the edge ending cycle t+MEM_LAT capture MRDATA into
//      IDATA (fetch) or DATAI (load); pop; next state ISSUE if queue non-empty, else RELEASE.
//    RELEASE: HLT=0 for exactly one cycle; core advances on its ending edge; -> ISSUE.
//  - HLT=1 in ISSUE and WAIT. Core inputs stay stable while HLT=1; arbiter latches them anyway.
//  - MBE=1111 for reads. MRD and MWR never high together; at most one strobe per cycle.
//  - RD&WR both 1: WR taken, RD ignored, ERR set (cleared only by reset).
//  - IDATA/DATAI change only on their capture edge; DATAI keeps old value on non-load steps.
//  - Cycles per step, L=MEM_LAT: fetch only L+2; store+fetch L+3; load+fetch 2L+3.
//  - STALLS increments every cycle HLT=1 (including cycles right after reset), no wrap.
//  - No address decoding or alignment checks; BE passed through unchanged.
// TESTING
//  1 Reset: hold RES=0 3 cycles -> HLT=1, MRD=MWR=0, IDATA=0, STALLS=0; release -> MRD=1 at IADDR next cycle.
//  2 Fetch only, L=1, IADDR=0x10, mem[0x10]=0x00000013 -> MRD@t0, IDATA=0x13 from t0+2, HLT=0 only at t0+2.
//  3 Load+fetch, DATA_PRIO=1, L=2, DADDR=0x80 (mem=0xDEADBEEF) -> MRD@0x80 then MRD@IADDR, DATAI=0xDEADBEEF, RELEASE at cycle 7.
//  4 Store, DADDR=0x84, DATAO=0x000000AB, BE=0001 -> one MWR cycle with those values, then fetch; RELEASE after L+3 cycles.
//  5 RD=WR=1 -> only MWR issued, ERR=1 and stays 1 until reset.
//  6 Reset asserted during WAIT (L=4) -> at that edge HLT=1, MRD=0, IDATA unchanged-to-0, late MRDATA ignored.

Source files
------------

// File: rtl/dark_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dark_mem_arbiter
//   Shares one single-port synchronous RAM between the darkriscv instruction
//   fetch port and its data port. Each core step is broken into at most two
//   memory accesses: an optional data access (load or store) and an
//   instruction fetch. DATA_PRIO selects which of the two goes first. The core
//   is held with HLT while the accesses run. HLT drops for exactly one RELEASE
//   cycle, and the core advances on the edge that ends that cycle.
//
// Parameters
//   MEM_LAT    read latency in cycles, 1..4 (MRD in cycle t -> MRDATA in t+MEM_LAT)
//   DATA_PRIO  1: data access before fetch, 0: fetch before data access
//
// Ports
//   CLK, RES               clock; synchronous active-low reset
//   IADDR / IDATA          fetch address in / registered instruction out
//   DADDR, DATAO, BE       data address, store data, byte enables
//   WR, RD                 store / load request (both high: store wins, ERR set)
//   DATAI                  registered load data
//   HLT                    stall to core, low only in the RELEASE cycle
//   MADDR, MWDATA, MBE     memory address, write data, byte enables
//   MWR, MRD, MRDATA       memory write strobe, read strobe, read data
//   ERR                    sticky RD&WR protocol error
//   STALLS                 saturating count of HLT=1 cycles since reset
// -----------------------------------------------------------------------------
module dark_mem_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter bit DATA_PRIO = 1'b1
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [31:0] IADDR,
   output logic [31:0] IDATA,
   input  logic [31:0] DADDR,
   input  logic [31:0] DATAO,
   output logic [31:0] DATAI,
   input  logic [3:0]  BE,
   input  logic        WR,
   input  logic        RD,
   output logic        HLT,
   output logic [31:0] MADDR,
   output logic [31:0] MWDATA,
   output logic [3:0]  MBE,
   output logic        MWR,
   output logic        MRD,
   input  logic [31:0] MRDATA,
   output logic        ERR,
   output logic [31:0] STALLS
);

   typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_RELEASE} state_t;

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic        run_q, run_d;           // low for the single idle cycle after reset
   logic        fresh_q, fresh_d;       // first ISSUE cycle of a step: use live core inputs
   logic        data_pend_q, data_pend_d;
   logic        fetch_pend_q, fetch_pend_d;
   logic        is_wr_q, is_wr_d;
   logic        cur_fetch_q, cur_fetch_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic [31:0] iaddr_q, iaddr_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] datao_q, datao_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] idata_q, idata_d;
   logic [31:0] datai_q, datai_d;
   logic        err_q, err_d;
   logic [31:0] stalls_q, stalls_d;

   // The step's pending list as seen this cycle: on the first ISSUE cycle the
   // core inputs are used directly so the first strobe costs no extra cycle.
   logic        eff_data_pend, eff_fetch_pend, eff_is_wr, head_is_data;
   logic [31:0] eff_iaddr, eff_daddr, eff_datao;
   logic [3:0]  eff_be;
   logic        hlt_c, mrd_c, mwr_c;
   logic [31:0] maddr_c, mwdata_c;
   logic [3:0]  mbe_c;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case below can leave one unassigned and infer a latch.
      state_d      = state_q;
      run_d        = 1'b1;
      fresh_d      = fresh_q;
      data_pend_d  = data_pend_q;
      fetch_pend_d = fetch_pend_q;
      is_wr_d      = is_wr_q;
      cur_fetch_d  = cur_fetch_q;
      lat_cnt_d    = lat_cnt_q;
      iaddr_d      = iaddr_q;
      daddr_d      = daddr_q;
      datao_d      = datao_q;
      be_d         = be_q;
      idata_d      = idata_q;
      datai_d      = datai_q;
      err_d        = err_q;
      mrd_c        = 1'b0;
      mwr_c        = 1'b0;
      maddr_c      = 32'd0;
      mwdata_c     = 32'd0;
      mbe_c        = 4'd0;

      eff_data_pend  = fresh_q ? (RD | WR) : data_pend_q;
      eff_fetch_pend = fresh_q ? 1'b1      : fetch_pend_q;
      eff_is_wr      = fresh_q ? WR        : is_wr_q;
      eff_iaddr      = fresh_q ? IADDR     : iaddr_q;
      eff_daddr      = fresh_q ? DADDR     : daddr_q;
      eff_datao      = fresh_q ? DATAO     : datao_q;
      eff_be         = fresh_q ? BE        : be_q;
      head_is_data   = eff_data_pend && (DATA_PRIO || !eff_fetch_pend);

      hlt_c    = (state_q != ST_RELEASE);
      stalls_d = (hlt_c && (stalls_q != '1)) ? stalls_q + 32'd1 : stalls_q;

      case (state_q)
         ST_ISSUE: begin
            if (run_q) begin
               if (fresh_q) begin
                  iaddr_d = IADDR;
                  daddr_d = DADDR;
                  datao_d = DATAO;
                  be_d    = BE;
                  is_wr_d = WR;
                  err_d   = err_q | (RD & WR);
               end
               fresh_d = 1'b0;
               if (head_is_data && eff_is_wr) begin
                  mwr_c        = 1'b1;
                  maddr_c      = eff_daddr;
                  mwdata_c     = eff_datao;
                  mbe_c        = eff_be;
                  data_pend_d  = 1'b0;
                  fetch_pend_d = eff_fetch_pend;
                  state_d      = eff_fetch_pend ? ST_ISSUE : ST_RELEASE;
               end else begin
                  mrd_c        = 1'b1;
                  mbe_c        = 4'hF;
                  maddr_c      = head_is_data ? eff_daddr : eff_iaddr;
                  cur_fetch_d  = !head_is_data;
                  data_pend_d  = eff_data_pend && !head_is_data;
                  fetch_pend_d = eff_fetch_pend && head_is_data;
                  lat_cnt_d    = 3'd0;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // The last WAIT cycle is the one in which MRDATA is valid.
            if (lat_cnt_q == LAT_LAST) begin
               if (cur_fetch_q) idata_d = MRDATA;
               else             datai_d = MRDATA;
               state_d = (data_pend_q || fetch_pend_q) ? ST_ISSUE : ST_RELEASE;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_ISSUE;
            fresh_d = 1'b1;
         end
         default: state_d = ST_ISSUE;
      endcase
   end

   // NOTE: reset is synchronous (sampled on the edge like any other input) and
   // all state updates use non-blocking assignments so every flop sees the
   // pre-edge values of the others.
   always_ff @(posedge CLK) begin
      if (!RES) begin
         state_q      <= ST_ISSUE;
         run_q        <= 1'b0;
         fresh_q      <= 1'b1;
         data_pend_q  <= 1'b0;
         fetch_pend_q <= 1'b0;
         is_wr_q      <= 1'b0;
         cur_fetch_q  <= 1'b0;
         lat_cnt_q    <= 3'd0;
         iaddr_q      <= 32'd0;
         daddr_q      <= 32'd0;
         datao_q      <= 32'd0;
         be_q         <= 4'd0;
         idata_q      <= 32'd0;
         datai_q      <= 32'd0;
         err_q        <= 1'b0;
         stalls_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         fresh_q      <= fresh_d;
         data_pend_q  <= data_pend_d;
         fetch_pend_q <= fetch_pend_d;
         is_wr_q      <= is_wr_d;
         cur_fetch_q  <= cur_fetch_d;
         lat_cnt_q    <= lat_cnt_d;
         iaddr_q      <= iaddr_d;
         daddr_q      <= daddr_d;
         datao_q      <= datao_d;
         be_q         <= be_d;
         idata_q      <= idata_d;
         datai_q      <= datai_d;
         err_q        <= err_d;
         stalls_q     <= stalls_d;
      end
   end

   assign HLT    = hlt_c;
   assign MRD    = mrd_c;
   assign MWR    = mwr_c;
   assign MADDR  = maddr_c;
   assign MWDATA = mwdata_c;
   assign MBE    = mbe_c;
   assign IDATA  = idata_q;
   assign DATAI  = datai_q;
   assign ERR    = err_q;
   assign STALLS = stalls_q;

endmodule

// File: tb/tb_dark_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dark_mem_arbiter
//   Acts as the darkriscv core and the RAM around dark_mem_arbiter. The core
//   side issues one step at a time and pushes the expected outcome of the step
//   (memory operations in order, IDATA, DATAI, ERR, step length, STALLS) into a
//   scoreboard. A monitor watches the memory strobes and, on every RELEASE
//   cycle, pops and compares.
// -----------------------------------------------------------------------------
module tb_dark_mem_arbiter;

   localparam int MEM_LAT   = 2;
   localparam bit DATA_PRIO = 1'b1;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic [31:0] IADDR = 32'd0, DADDR = 32'd0, DATAO = 32'd0;
   logic [3:0]  BE = 4'd0;
   logic        WR = 1'b0, RD = 1'b0;
   logic [31:0] IDATA, DATAI, MADDR, MWDATA, MRDATA, STALLS;
   logic [3:0]  MBE;
   logic        HLT, MWR, MRD, ERR;

   always #5 CLK = ~CLK;

   dark_mem_arbiter #(.MEM_LAT(MEM_LAT), .DATA_PRIO(DATA_PRIO)) dut (
      .CLK(CLK), .RES(RES),
      .IADDR(IADDR), .IDATA(IDATA),
      .DADDR(DADDR), .DATAO(DATAO), .DATAI(DATAI),
      .BE(BE), .WR(WR), .RD(RD), .HLT(HLT),
      .MADDR(MADDR), .MWDATA(MWDATA), .MBE(MBE),
      .MWR(MWR), .MRD(MRD), .MRDATA(MRDATA),
      .ERR(ERR), .STALLS(STALLS)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_op_t;

   typedef struct packed {
      logic [31:0] idata;
      logic [31:0] datai;
      logic        err;
      logic [31:0] stalls;
      logic [31:0] cycles;
      logic [31:0] n_ops;
   } step_exp_t;

   mem_op_t   exp_ops[$];
   mem_op_t   obs_ops[$];
   step_exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   bit active = 1'b0;
   bit abort  = 1'b0;
   int cyc    = 0;

   // Reference state kept at the level of whole steps.
   logic [31:0] ref_mem [256];
   logic [31:0] idata_exp = 32'd0, datai_exp = 32'd0, stall_acc = 32'd0;
   logic        err_exp = 1'b0;

   function automatic logic [31:0] init_word(int i);
      if (i == 4)  return 32'h0000_0013;
      if (i == 32) return 32'hDEAD_BEEF;
      return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic int widx(logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- RAM model
   logic [31:0] mem [256];
   logic [31:0] pipe [MEM_LAT];
   bit          mem_ready = 1'b0;

   assign MRDATA = pipe[MEM_LAT-1];

   always @(posedge CLK) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (MWR) begin
         for (int b = 0; b < 4; b++)
            if (MBE[b]) mem[widx(MADDR)][8*b +: 8] <= MWDATA[8*b +: 8];
      end
      pipe[0] <= MRD ? mem[widx(MADDR)] : 32'hBAD0_BAD0;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end

   // ------------------------------------------------------ stimulus + model
   task automatic issue_step(input logic rd, input logic wr, input logic [31:0] ia,
                             input logic [31:0] da, input logic [31:0] dout,
                             input logic [3:0] be);
      step_exp_t e;
      mem_op_t   op;
      int        n = 0;
      bit        has_data = rd | wr;
      IADDR = ia; DADDR = da; DATAO = dout; BE = be; RD = rd; WR = wr;
      for (int slot = 0; slot < 2; slot++) begin
         bit do_data = ((slot == 0) == DATA_PRIO);
         if (do_data && has_data && wr) begin
            op = '{wr: 1'b1, addr: da, wdata: dout, be: be};
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[widx(da)][8*b +: 8] = dout[8*b +: 8];
            exp_ops.push_back(op); n++;
         end else if (do_data && has_data) begin
            op = '{wr: 1'b0, addr: da, wdata: 32'd0, be: 4'hF};
            datai_exp = ref_mem[widx(da)];
            exp_ops.push_back(op); n++;
         end else if (!do_data) begin
            op = '{wr: 1'b0, addr: ia, wdata: 32'd0, be: 4'hF};
            idata_exp = ref_mem[widx(ia)];
            exp_ops.push_back(op); n++;
         end
      end
      err_exp = err_exp | (rd & wr);
      e.cycles = !has_data ? 32'(MEM_LAT + 2) : (wr ? 32'(MEM_LAT + 3) : 32'(2 * MEM_LAT + 3));
      stall_acc = stall_acc + e.cycles - 32'd1;
      e.idata  = idata_exp;
      e.datai  = datai_exp;
      e.err    = err_exp;
      e.stalls = stall_acc;
      e.n_ops  = 32'(n);
      exp_q.push_back(e);
   endtask

   task automatic wait_release();
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge CLK);
         if (!HLT) ok = 1'b1;
      end
      if (!ok) begin
         check("step_timeout", 32'd0, 32'd1);
         abort = 1'b1;
      end else begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RES = 1'b1;
      @(posedge CLK);
      #1;
      active = 1'b1;
   endtask

   task automatic random_step();
      int          kind = $urandom_range(0, 9);
      logic [31:0] ia = {22'd0, 8'($urandom_range(0, 47)), 2'b00};
      logic [31:0] da = {22'd0, 8'($urandom_range(0, 47)), 2'b00};
      logic [31:0] dv = $urandom;
      logic [3:0]  bv = 4'($urandom_range(1, 15));
      case (kind)
         0, 1, 2: issue_step(1'b0, 1'b0, ia, da, dv, bv);
         3, 4, 5: issue_step(1'b1, 1'b0, ia, da, dv, bv);
         9:       issue_step(1'b1, 1'b1, ia, da, dv, bv);
         default: issue_step(1'b0, 1'b1, ia, da, dv, bv);
      endcase
      wait_release();
   endtask

   // ---------------------------------------------------------------- monitor
   always @(negedge CLK) begin : monitor
      step_exp_t e;
      mem_op_t   eo, oo;
      check("single_strobe", 32'(MRD & MWR), 32'd0);
      if (active) begin
         cyc++;
         if (MRD || MWR) begin
            oo.wr    = MWR;
            oo.addr  = MADDR;
            oo.wdata = MWR ? MWDATA : 32'd0;
            oo.be    = MBE;
            obs_ops.push_back(oo);
         end
         if (!HLT) begin
            if (exp_q.size() == 0) begin
               check("unexpected_release", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("step_cycles", 32'(cyc), e.cycles);
               check("idata", IDATA, e.idata);
               check("datai", DATAI, e.datai);
               check("err", 32'(ERR), 32'(e.err));
               check("stalls", STALLS, e.stalls);
               check("op_count", 32'(obs_ops.size()), e.n_ops);
               for (int i = 0; i < int'(e.n_ops); i++) begin
                  eo = exp_ops.pop_front();
                  if (i < obs_ops.size()) begin
                     check("op_is_write", 32'(obs_ops[i].wr), 32'(eo.wr));
                     check("op_addr", obs_ops[i].addr, eo.addr);
                     check("op_be", 32'(obs_ops[i].be), 32'(eo.be));
                     if (eo.wr) check("op_wdata", obs_ops[i].wdata, eo.wdata);
                  end
               end
            end
            obs_ops.delete();
            cyc = 0;
         end
      end
   end

   // --------------------------------------------------------------- sequence
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      // Reset held for three edges: everything idle and cleared.
      RES = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_hlt", 32'(HLT), 32'd1);
      check("rst_mrd", 32'(MRD), 32'd0);
      check("rst_mwr", 32'(MWR), 32'd0);
      check("rst_idata", IDATA, 32'd0);
      check("rst_datai", DATAI, 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_stalls", STALLS, 32'd0);

      // Fetch-only step at 0x10: first read strobe lands the cycle after release.
      stall_acc = 32'd1;
      issue_step(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0);
      release_reset();
      @(negedge CLK);
      check("first_mrd", 32'(MRD), 32'd1);
      check("first_maddr", MADDR, 32'h10);
      wait_release();

      // Directed load, store, RD&WR and plain fetch.
      if (!abort) begin issue_step(1'b1, 1'b0, 32'h14, 32'h80, 32'h0, 4'h0); wait_release(); end
      if (!abort) begin issue_step(1'b0, 1'b1, 32'h84, 32'h84, 32'h0000_00AB, 4'b0001); wait_release(); end
      if (!abort) begin issue_step(1'b1, 1'b1, 32'h18, 32'h88, 32'h5555_AAAA, 4'hF); wait_release(); end
      if (!abort) begin issue_step(1'b0, 1'b0, 32'h88, 32'h0, 32'h0, 4'h0); wait_release(); end

      for (int s = 0; s < 40 && !abort; s++) random_step();

      // Reset while a load is waiting for memory data.
      if (!abort) begin
         bit seen = 1'b0;
         issue_step(1'b1, 1'b0, 32'h20, 32'h80, 32'h0, 4'h0);
         for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge CLK);
            if (MRD) seen = 1'b1;
         end
         check("wait_entry_mrd", 32'(seen), 32'd1);
         @(posedge CLK);
         #1;
         active = 1'b0;
         RES    = 1'b0;
         exp_q.delete();
         exp_ops.delete();
         obs_ops.delete();
         cyc = 0;
         @(posedge CLK);
         @(negedge CLK);
         check("wait_rst_hlt", 32'(HLT), 32'd1);
         check("wait_rst_mrd", 32'(MRD), 32'd0);
         check("wait_rst_idata", IDATA, 32'd0);
         check("wait_rst_datai", DATAI, 32'd0);
         check("wait_rst_err", 32'(ERR), 32'd0);
         check("wait_rst_stalls", STALLS, 32'd0);
         repeat (MEM_LAT + 1) @(negedge CLK);
         check("late_data_idata", IDATA, 32'd0);
         check("late_data_datai", DATAI, 32'd0);

         idata_exp = 32'd0;
         datai_exp = 32'd0;
         err_exp   = 1'b0;
         stall_acc = 32'd1;
         issue_step(1'b1, 1'b0, 32'h24, 32'h80, 32'h0, 4'h0);
         release_reset();
         wait_release();
      end

      for (int s = 0; s < 12 && !abort; s++) random_step();

      repeat (2) @(negedge CLK);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
